// File: rtl/countdown_core_pkg.sv
// rtl/countdown_core_pkg.sv - shared state encodings, BCD limits and preset helper for the egg timer
package countdown_core_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_PAUSE = 3'd2;
  localparam logic [2:0] ST_ALARM = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [3:0] BCD_MAX_SEC_ONES = 4'd9;
  localparam logic [3:0] BCD_MAX_SEC_TENS = 4'd5;
  localparam logic [3:0] BCD_MAX_MIN_ONES = 4'd9;
  localparam logic [3:0] BCD_MAX_MIN_TENS = 4'd9;

  // Packs a binary mm:ss pair into {min_tens,min_ones,sec_tens,sec_ones}.
  function automatic logic [15:0] to_bcd(input int mm, input int ss);
    logic [3:0] w_mt;
    logic [3:0] w_mo;
    logic [3:0] w_st;
    logic [3:0] w_so;
    w_mt = 4'(mm / 10);
    w_mo = 4'(mm % 10);
    w_st = 4'(ss / 10);
    w_so = 4'(ss % 10);
    return {w_mt, w_mo, w_st, w_so};
  endfunction

endpackage

// File: rtl/countdown_core_bcd_digit_dec.sv
// rtl/countdown_core_bcd_digit_dec.sv - one BCD digit of the ripple-borrow decrement chain
module countdown_core_bcd_digit_dec
  import countdown_core_pkg::*;
#(
  parameter logic [3:0] MAX_DIGIT = BCD_MAX_SEC_ONES
) (
  input  logic [3:0] i_digit,
  input  logic       i_borrow,
  output logic [3:0] o_digit,
  output logic       o_borrow
);

  logic w_is_zero;

  assign w_is_zero = (i_digit == 4'd0);
  assign o_borrow  = i_borrow && w_is_zero;

  always_comb begin
    o_digit = i_digit;
    if (i_borrow) begin
      if (w_is_zero) begin
        o_digit = MAX_DIGIT;
      end else begin
        o_digit = i_digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/countdown_core.sv
// rtl/countdown_core.sv - mm:ss BCD countdown FSM with alarm window, driven by a 1 s tick enable
module countdown_core
  import countdown_core_pkg::*;
#(
  parameter int PRESET_MIN = 3,
  parameter int PRESET_SEC = 0,
  parameter int ALARM_SECS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_1s,
  input  logic        timer_on,
  input  logic        load,
  output logic [15:0] digits,
  output logic        running,
  output logic        alarm,
  output logic        done
);

  localparam int ACTR_W = (ALARM_SECS < 1) ? 1 : $clog2(ALARM_SECS + 1);
  localparam logic [15:0] PRESET_BCD = to_bcd(PRESET_MIN, PRESET_SEC);
  localparam logic [ACTR_W-1:0] ALARM_END = ACTR_W'(ALARM_SECS);

  generate
    if (PRESET_MIN < 0 || PRESET_MIN > 99 || PRESET_SEC < 0 || PRESET_SEC > 59
        || ALARM_SECS < 0) begin : g_bad_preset
      $error("countdown_core: preset or alarm length out of range");
    end
  endgenerate

  logic [2:0]        r_state;
  logic [15:0]       r_digits;
  logic [ACTR_W-1:0] r_alarm_ctr;

  logic [15:0]       w_dec_digits;
  logic [3:0]        w_borrow;
  logic              w_at_zero;
  logic              w_dec_zero;
  logic [ACTR_W-1:0] w_ctr_next;

  countdown_core_bcd_digit_dec #(.MAX_DIGIT(BCD_MAX_SEC_ONES)) u_sec_ones (
    .i_digit  (r_digits[3:0]),
    .i_borrow (1'b1),
    .o_digit  (w_dec_digits[3:0]),
    .o_borrow (w_borrow[0])
  );

  countdown_core_bcd_digit_dec #(.MAX_DIGIT(BCD_MAX_SEC_TENS)) u_sec_tens (
    .i_digit  (r_digits[7:4]),
    .i_borrow (w_borrow[0]),
    .o_digit  (w_dec_digits[7:4]),
    .o_borrow (w_borrow[1])
  );

  countdown_core_bcd_digit_dec #(.MAX_DIGIT(BCD_MAX_MIN_ONES)) u_min_ones (
    .i_digit  (r_digits[11:8]),
    .i_borrow (w_borrow[1]),
    .o_digit  (w_dec_digits[11:8]),
    .o_borrow (w_borrow[2])
  );

  countdown_core_bcd_digit_dec #(.MAX_DIGIT(BCD_MAX_MIN_TENS)) u_min_tens (
    .i_digit  (r_digits[15:12]),
    .i_borrow (w_borrow[2]),
    .o_digit  (w_dec_digits[15:12]),
    .o_borrow (w_borrow[3])
  );

  // A borrow out of the top digit only happens when every digit is zero.
  assign w_at_zero  = w_borrow[3];
  assign w_dec_zero = (w_dec_digits == 16'h0000);
  assign w_ctr_next = r_alarm_ctr + ACTR_W'(1);

  always_ff @(posedge clk) begin
    if (reset || load) begin
      r_state     <= ST_IDLE;
      r_digits    <= PRESET_BCD;
      r_alarm_ctr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (timer_on) begin
            if (w_at_zero) begin
              r_state     <= ST_ALARM;
              r_alarm_ctr <= '0;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          // Reaching 00:00 wins over a simultaneous pause request.
          if (tick_1s && !w_at_zero) begin
            r_digits <= w_dec_digits;
            if (w_dec_zero) begin
              r_state     <= ST_ALARM;
              r_alarm_ctr <= '0;
            end else if (!timer_on) begin
              r_state <= ST_PAUSE;
            end
          end else if (!timer_on) begin
            r_state <= ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (timer_on) begin
            r_state <= ST_RUN;
          end
        end
        ST_ALARM: begin
          r_digits <= 16'h0000;
          if (ALARM_SECS == 0 || !timer_on) begin
            r_state <= ST_DONE;
          end else if (tick_1s) begin
            r_alarm_ctr <= w_ctr_next;
            if (w_ctr_next == ALARM_END) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_digits <= 16'h0000;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign digits  = r_digits;
  assign running = (r_state == ST_RUN);
  assign alarm   = (r_state == ST_ALARM);
  assign done    = (r_state == ST_DONE);

endmodule

// File: tb/tb_countdown_core.sv
// tb/tb_countdown_core.sv - scoreboard bench for countdown_core across three preset configurations
module tb_countdown_core;

  localparam logic [2:0] F_IDLE = 3'b000;
  localparam logic [2:0] F_RUN  = 3'b100;
  localparam logic [2:0] F_ALM  = 3'b010;
  localparam logic [2:0] F_DONE = 3'b001;

  typedef struct {
    int          cyc;
    int          inst;
    logic [15:0] d;
    logic [2:0]  f;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic [2:0]  rst;
  logic [2:0]  on;
  logic [2:0]  tick;
  logic [2:0]  ld;
  logic [15:0] dg [3];
  logic [2:0]  run_o;
  logic [2:0]  alm_o;
  logic [2:0]  dn_o;

  int   edge_cnt = 0;
  int   n_vec    = 0;
  int   n_err    = 0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  countdown_core #(.PRESET_MIN(0), .PRESET_SEC(5), .ALARM_SECS(10)) u_dut0 (
    .clk(clk), .reset(rst[0]), .tick_1s(tick[0]), .timer_on(on[0]), .load(ld[0]),
    .digits(dg[0]), .running(run_o[0]), .alarm(alm_o[0]), .done(dn_o[0])
  );

  countdown_core #(.PRESET_MIN(10), .PRESET_SEC(0), .ALARM_SECS(10)) u_dut1 (
    .clk(clk), .reset(rst[1]), .tick_1s(tick[1]), .timer_on(on[1]), .load(ld[1]),
    .digits(dg[1]), .running(run_o[1]), .alarm(alm_o[1]), .done(dn_o[1])
  );

  countdown_core #(.PRESET_MIN(0), .PRESET_SEC(0), .ALARM_SECS(0)) u_dut2 (
    .clk(clk), .reset(rst[2]), .tick_1s(tick[2]), .timer_on(on[2]), .load(ld[2]),
    .digits(dg[2]), .running(run_o[2]), .alarm(alm_o[2]), .done(dn_o[2])
  );

  // Monitor: compares queued expectations against the outputs of the cycle they target.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= edge_cnt) begin
      exp_t  e;
      logic [2:0] act_f;
      e = q.pop_front();
      n_vec++;
      act_f = {run_o[e.inst], alm_o[e.inst], dn_o[e.inst]};
      if (e.cyc != edge_cnt) begin
        n_err++;
        $display("FAIL %s: expectation for cycle %0d seen at cycle %0d", e.name, e.cyc, edge_cnt);
      end else if (dg[e.inst] !== e.d || act_f !== e.f) begin
        n_err++;
        $display("FAIL %s (dut%0d cyc %0d): got digits=%h flags=%b, want digits=%h flags=%b",
                 e.name, e.inst, edge_cnt, dg[e.inst], act_f, e.d, e.f);
      end
    end
  end

  task automatic step(input int inst, input logic r, input logic o, input logic t,
                      input logic l, input logic chk, input logic [15:0] ed,
                      input logic [2:0] ef, input string nm);
    rst[inst]  = r;
    on[inst]   = o;
    tick[inst] = t;
    ld[inst]   = l;
    if (chk) q.push_back('{edge_cnt + 1, inst, ed, ef, nm});
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] t1_exp [5];
    t1_exp = '{16'h0004, 16'h0003, 16'h0002, 16'h0001, 16'h0000};
    rst = 3'b111; on = '0; tick = '0; ld = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = '0;

    // Config 0:05, 10 s alarm: countdown, alarm window, silence, pause.
    step(0, 1, 0, 0, 0, 1, 16'h0005, F_IDLE, "reset0");
    step(0, 0, 1, 0, 0, 1, 16'h0005, F_RUN, "start0");
    for (int i = 0; i < 5; i++)
      step(0, 0, 1, 1, 0, 1, t1_exp[i], (i == 4) ? F_ALM : F_RUN, "countdown");
    for (int i = 1; i <= 10; i++)
      step(0, 0, 1, 1, 0, 1, 16'h0000, (i == 10) ? F_DONE : F_ALM, "alarm_window");
    step(0, 0, 1, 1, 0, 1, 16'h0000, F_DONE, "done_hold");
    step(0, 0, 0, 0, 1, 1, 16'h0005, F_IDLE, "load_from_done");
    step(0, 0, 0, 1, 0, 1, 16'h0005, F_IDLE, "idle_tick_ignored");
    step(0, 0, 1, 0, 0, 1, 16'h0005, F_RUN, "restart0");
    for (int i = 0; i < 5; i++)
      step(0, 0, 1, 1, 0, (i == 4), 16'h0000, F_ALM, "reach_alarm");
    step(0, 0, 1, 1, 0, 1, 16'h0000, F_ALM, "alarm_tick1");
    step(0, 0, 1, 1, 0, 1, 16'h0000, F_ALM, "alarm_tick2");
    step(0, 0, 0, 1, 0, 1, 16'h0000, F_DONE, "silence");
    step(0, 0, 0, 0, 1, 1, 16'h0005, F_IDLE, "load_pause_test");
    step(0, 0, 1, 0, 0, 1, 16'h0005, F_RUN, "run_pause_test");
    step(0, 0, 1, 1, 0, 1, 16'h0004, F_RUN, "pre_pause_1");
    step(0, 0, 1, 1, 0, 1, 16'h0003, F_RUN, "pre_pause_2");
    step(0, 0, 1, 1, 0, 1, 16'h0002, F_RUN, "pre_pause_3");
    step(0, 0, 0, 1, 0, 1, 16'h0001, F_IDLE, "pause_with_tick");
    step(0, 0, 0, 1, 0, 1, 16'h0001, F_IDLE, "paused_tick_a");
    step(0, 0, 0, 1, 0, 1, 16'h0001, F_IDLE, "paused_tick_b");
    step(0, 0, 1, 0, 0, 1, 16'h0001, F_RUN, "resume");
    step(0, 0, 1, 1, 0, 1, 16'h0000, F_ALM, "resume_to_alarm");
    step(0, 0, 0, 0, 0, 0, 16'h0000, F_IDLE, "idle0");

    // Config 10:00: borrow chain, load with tick at 02:17, mid-run reset.
    step(1, 1, 0, 0, 0, 1, 16'h1000, F_IDLE, "reset1");
    step(1, 0, 1, 0, 0, 1, 16'h1000, F_RUN, "start1");
    step(1, 0, 1, 1, 0, 1, 16'h0959, F_RUN, "borrow_10m");
    for (int i = 0; i < 462; i++)
      step(1, 0, 1, 1, 0, (i == 461), 16'h0217, F_RUN, "reach_0217");
    step(1, 0, 1, 1, 1, 1, 16'h1000, F_IDLE, "load_with_tick");
    step(1, 0, 1, 0, 0, 1, 16'h1000, F_RUN, "rerun1");
    for (int i = 0; i < 540; i++)
      step(1, 0, 1, 1, 0, (i == 539), 16'h0100, F_RUN, "reach_0100");
    step(1, 0, 1, 1, 0, 1, 16'h0059, F_RUN, "borrow_1m");
    step(1, 0, 1, 1, 0, 1, 16'h0058, F_RUN, "after_0059");
    step(1, 1, 1, 1, 0, 1, 16'h1000, F_IDLE, "reset_mid_run");
    step(1, 0, 0, 0, 0, 1, 16'h1000, F_IDLE, "idle_after_reset");

    // Config 0:00 with zero-length alarm.
    step(2, 1, 0, 0, 0, 1, 16'h0000, F_IDLE, "reset2");
    step(2, 0, 0, 1, 0, 1, 16'h0000, F_IDLE, "zero_idle_off");
    step(2, 0, 1, 0, 0, 1, 16'h0000, F_ALM, "zero_to_alarm");
    step(2, 0, 1, 0, 0, 1, 16'h0000, F_DONE, "alarm0_one_cycle");
    step(2, 0, 1, 1, 0, 1, 16'h0000, F_DONE, "no_auto_restart");
    step(2, 0, 0, 0, 0, 0, 16'h0000, F_IDLE, "idle2");

    repeat (3) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations never checked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
